// File: rtl/prga_pkg.sv
// rtl/prga_pkg.sv - shared types and constants for the RC4 PRGA stream engine
package prga_pkg;

  localparam int S_W     = 8;
  localparam int S_DEPTH = 256;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RD_LEN,
    ST_WR_LEN,
    ST_START,
    ST_RD_I,
    ST_GET_I,
    ST_RD_J,
    ST_GET_J,
    ST_WR_I,
    ST_WR_J,
    ST_RD_PAD,
    ST_FIN,
    ST_DONE
  } prga_state_t;

  // Largest message body that fits behind the header in the address space.
  function automatic int len_max(input int addr_w, input int len_bytes);
    return (1 << addr_w) - len_bytes;
  endfunction

endpackage

// File: rtl/prga_stream.sv
// rtl/prga_stream.sv - RC4 PRGA with drop[N], wide addressing and multi-byte length header
module prga_stream
  import prga_pkg::*;
#(
  parameter int DROP_N    = 0,
  parameter int ADDR_W    = 8,
  parameter int LEN_BYTES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  output logic              rdy,
  output logic [S_W-1:0]    s_addr,
  input  logic [S_W-1:0]    s_rddata,
  output logic [S_W-1:0]    s_wrdata,
  output logic              s_wren,
  output logic [ADDR_W-1:0] ct_addr,
  input  logic [7:0]        ct_rddata,
  output logic [ADDR_W-1:0] pt_addr,
  input  logic [7:0]        pt_rddata,
  output logic [7:0]        pt_wrdata,
  output logic              pt_wren
);

  localparam logic [ADDR_W-1:0] LB_A     = ADDR_W'(LEN_BYTES);
  localparam logic [ADDR_W-1:0] ONE_A    = ADDR_W'(1);
  localparam logic [16:0]       LMAX     = 17'(len_max(ADDR_W, LEN_BYTES));
  localparam logic [31:0]       DROP_U   = 32'(DROP_N);
  localparam logic              HDR_LAST = 1'(LEN_BYTES - 1);

  prga_state_t       state_q, state_d;
  logic              rdy_q, rdy_d;
  logic [S_W-1:0]    s_addr_q, s_addr_d;
  logic [S_W-1:0]    s_wrdata_q, s_wrdata_d;
  logic              s_wren_q, s_wren_d;
  logic [ADDR_W-1:0] ct_addr_q, ct_addr_d;
  logic [ADDR_W-1:0] pt_addr_q, pt_addr_d;
  logic [7:0]        pt_wrdata_q, pt_wrdata_d;
  logic              pt_wren_q, pt_wren_d;
  logic [S_W-1:0]    i_q, i_d, j_q, j_d, si_q, si_d, sj_q, sj_d;
  logic [7:0]        ct_byte_q, ct_byte_d;
  logic [15:0]       len_raw_q, len_raw_d;
  logic [ADDR_W-1:0] len_q, len_d, k_q, k_d;
  logic [31:0]       drop_cnt_q, drop_cnt_d;
  logic              hdr_idx_q, hdr_idx_d;
  logic              msg_q, msg_d, pend_q, pend_d;

  logic              have_drop, have_msg, start_iter;
  logic [15:0]       hdr_full;
  logic              unused_pt;

  assign unused_pt = ^pt_rddata;
  assign have_drop = (drop_cnt_q != DROP_U);
  assign have_msg  = (k_q != len_q);

  always_comb begin
    state_d     = state_q;
    rdy_d       = rdy_q;
    s_addr_d    = s_addr_q;
    s_wrdata_d  = s_wrdata_q;
    s_wren_d    = s_wren_q;
    ct_addr_d   = ct_addr_q;
    pt_addr_d   = pt_addr_q;
    pt_wrdata_d = pt_wrdata_q;
    pt_wren_d   = pt_wren_q;
    i_d         = i_q;
    j_d         = j_q;
    si_d        = si_q;
    sj_d        = sj_q;
    ct_byte_d   = ct_byte_q;
    len_raw_d   = len_raw_q;
    len_d       = len_q;
    k_d         = k_q;
    drop_cnt_d  = drop_cnt_q;
    hdr_idx_d   = hdr_idx_q;
    msg_d       = msg_q;
    pend_d      = pend_q;
    start_iter  = 1'b0;
    hdr_full    = hdr_idx_q ? {ct_rddata, len_raw_q[7:0]} : {8'h00, ct_rddata};

    case (state_q)
      ST_IDLE: begin
        if (en) begin
          state_d    = ST_RD_LEN;
          rdy_d      = 1'b0;
          i_d        = '0;
          j_d        = '0;
          k_d        = '0;
          drop_cnt_d = '0;
          hdr_idx_d  = 1'b0;
          ct_addr_d  = '0;
          len_raw_d  = '0;
          msg_d      = 1'b0;
          pend_d     = 1'b0;
        end
      end
      ST_RD_LEN: begin
        pt_wren_d = 1'b0;
        state_d   = ST_WR_LEN;
      end
      ST_WR_LEN: begin
        pt_addr_d   = ADDR_W'(hdr_idx_q);
        pt_wrdata_d = ct_rddata;
        pt_wren_d   = 1'b1;
        if (hdr_idx_q) len_raw_d[15:8] = ct_rddata;
        else           len_raw_d[7:0]  = ct_rddata;
        if (hdr_idx_q == HDR_LAST) begin
          len_d   = ({1'b0, hdr_full} > LMAX) ? LMAX[ADDR_W-1:0] : hdr_full[ADDR_W-1:0];
          state_d = ST_START;
        end else begin
          hdr_idx_d = 1'(hdr_idx_q + 1'b1);
          ct_addr_d = ADDR_W'(hdr_idx_q) + ONE_A;
          state_d   = ST_RD_LEN;
        end
      end
      ST_START: begin
        pt_wren_d = 1'b0;
        if (have_drop || have_msg) begin
          start_iter = 1'b1;
        end else begin
          rdy_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      // The pad read of the previous iteration lands here, overlapped with the s[i] read.
      ST_RD_I: begin
        pt_wrdata_d = s_rddata ^ ct_byte_q;
        pt_wren_d   = pend_q;
        pend_d      = 1'b0;
        state_d     = ST_GET_I;
      end
      ST_GET_I: begin
        pt_wren_d = 1'b0;
        ct_byte_d = ct_rddata;
        si_d      = s_rddata;
        j_d       = j_q + s_rddata;
        s_addr_d  = j_q + s_rddata;
        state_d   = ST_RD_J;
      end
      ST_RD_J: begin
        state_d = ST_GET_J;
      end
      ST_GET_J: begin
        sj_d       = s_rddata;
        s_addr_d   = i_q;
        s_wrdata_d = s_rddata;
        s_wren_d   = 1'b1;
        state_d    = ST_WR_I;
      end
      ST_WR_I: begin
        s_addr_d   = j_q;
        s_wrdata_d = si_q;
        state_d    = ST_WR_J;
      end
      ST_WR_J: begin
        s_addr_d = si_q + sj_q;
        s_wren_d = 1'b0;
        state_d  = ST_RD_PAD;
      end
      ST_RD_PAD: begin
        pend_d    = msg_q;
        pt_addr_d = LB_A + k_q - ONE_A;
        if (have_drop || have_msg) start_iter = 1'b1;
        else                       state_d    = ST_FIN;
      end
      ST_FIN: begin
        pt_wrdata_d = s_rddata ^ ct_byte_q;
        pt_wren_d   = pend_q;
        pend_d      = 1'b0;
        state_d     = ST_DONE;
      end
      ST_DONE: begin
        pt_wren_d = 1'b0;
        rdy_d     = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Drop iterations always run ahead of message iterations.
    if (start_iter) begin
      if (have_drop) begin
        drop_cnt_d = drop_cnt_q + 32'd1;
        msg_d      = 1'b0;
      end else begin
        k_d       = k_q + ONE_A;
        ct_addr_d = LB_A + k_q;
        msg_d     = 1'b1;
      end
      i_d      = i_q + 8'd1;
      s_addr_d = i_q + 8'd1;
      state_d  = ST_RD_I;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rdy_q       <= 1'b1;
      s_addr_q    <= '0;
      s_wrdata_q  <= '0;
      s_wren_q    <= 1'b0;
      ct_addr_q   <= '0;
      pt_addr_q   <= '0;
      pt_wrdata_q <= '0;
      pt_wren_q   <= 1'b0;
      i_q         <= '0;
      j_q         <= '0;
      si_q        <= '0;
      sj_q        <= '0;
      ct_byte_q   <= '0;
      len_raw_q   <= '0;
      len_q       <= '0;
      k_q         <= '0;
      drop_cnt_q  <= '0;
      hdr_idx_q   <= 1'b0;
      msg_q       <= 1'b0;
      pend_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rdy_q       <= rdy_d;
      s_addr_q    <= s_addr_d;
      s_wrdata_q  <= s_wrdata_d;
      s_wren_q    <= s_wren_d;
      ct_addr_q   <= ct_addr_d;
      pt_addr_q   <= pt_addr_d;
      pt_wrdata_q <= pt_wrdata_d;
      pt_wren_q   <= pt_wren_d;
      i_q         <= i_d;
      j_q         <= j_d;
      si_q        <= si_d;
      sj_q        <= sj_d;
      ct_byte_q   <= ct_byte_d;
      len_raw_q   <= len_raw_d;
      len_q       <= len_d;
      k_q         <= k_d;
      drop_cnt_q  <= drop_cnt_d;
      hdr_idx_q   <= hdr_idx_d;
      msg_q       <= msg_d;
      pend_q      <= pend_d;
    end
  end

  assign rdy       = rdy_q;
  assign s_addr    = s_addr_q;
  assign s_wrdata  = s_wrdata_q;
  assign s_wren    = s_wren_q;
  assign ct_addr   = ct_addr_q;
  assign pt_addr   = pt_addr_q;
  assign pt_wrdata = pt_wrdata_q;
  assign pt_wren   = pt_wren_q;

endmodule

// File: tb/tb_prga_stream.sv
// tb/tb_prga_stream.sv - scoreboard bench for prga_stream across three parameter sets
module tb_prga_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [2:0]  en_v;
  logic [2:0]  rdy_v, s_wren_v, pt_wren_v;
  logic [15:0] pt_addr_v [3];
  logic [15:0] ct_addr_v [3];
  logic [7:0]  pt_data_v [3];
  logic [7:0]  s_addr_v  [3];

  int          ld_g, ld_mem;
  logic        ld_we;
  logic [15:0] ld_addr;
  logic [7:0]  ld_data;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_wr [3];
  int wr_cnt  [3];
  bit sb_en;

  typedef struct packed {
    logic [1:0]  g;
    logic [15:0] a;
    logic [7:0]  d;
  } exp_t;
  exp_t exp_q[$];

  logic [7:0] s_ref [256];
  logic [7:0] mi, mj;

  // Instance 0: plain RC4, 1: drop[3], 2: 10-bit addresses with 2-byte header.
  for (genvar g = 0; g < 3; g++) begin : g_inst
    localparam int AW = (g == 2) ? 10 : 8;
    localparam int LB = (g == 2) ? 2 : 1;
    localparam int DN = (g == 1) ? 3 : 0;
    logic [AW-1:0] ct_addr, pt_addr;
    logic [7:0]    s_addr, s_wrdata, s_rd, ct_rd, pt_wrdata;
    logic          s_wren, pt_wren;
    logic [7:0]    s_mem  [256];
    logic [7:0]    ct_mem [0:(1<<AW)-1];

    prga_stream #(.DROP_N(DN), .ADDR_W(AW), .LEN_BYTES(LB)) u_dut (
      .clk(clk), .rst_n(rst_n), .en(en_v[g]), .rdy(rdy_v[g]),
      .s_addr(s_addr), .s_rddata(s_rd), .s_wrdata(s_wrdata), .s_wren(s_wren),
      .ct_addr(ct_addr), .ct_rddata(ct_rd),
      .pt_addr(pt_addr), .pt_rddata(8'h00), .pt_wrdata(pt_wrdata), .pt_wren(pt_wren)
    );

    always @(posedge clk) begin
      if (s_wren) s_mem[s_addr] <= s_wrdata;
      else if (ld_we && ld_g == g && ld_mem == 0) s_mem[ld_addr[7:0]] <= ld_data;
      if (ld_we && ld_g == g && ld_mem == 1) ct_mem[ld_addr[AW-1:0]] <= ld_data;
      s_rd  <= s_mem[s_addr];
      ct_rd <= ct_mem[ct_addr];
    end

    assign pt_wren_v[g] = pt_wren;
    assign s_wren_v[g]  = s_wren;
    assign pt_addr_v[g] = 16'(pt_addr);
    assign ct_addr_v[g] = 16'(ct_addr);
    assign pt_data_v[g] = pt_wrdata;
    assign s_addr_v[g]  = s_addr;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : mon
    exp_t e;
    for (int g = 0; g < 3; g++) begin
      if (pt_wren_v[g]) begin
        last_wr[g] = cyc;
        wr_cnt[g]  = wr_cnt[g] + 1;
        if (sb_en) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL pt_write_unexpected inst=%0d actual addr=%0h data=%0h required none",
                     g, pt_addr_v[g], pt_data_v[g]);
          end else begin
            e = exp_q.pop_front();
            if ({2'(g), pt_addr_v[g], pt_data_v[g]} !== e) begin
              errors++;
              $display("FAIL pt_write inst=%0d actual addr=%0h data=%0h required inst=%0d addr=%0h data=%0h",
                       g, pt_addr_v[g], pt_data_v[g], e.g, e.a, e.d);
            end
          end
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic load_byte(input int g, input int mem, input int a, input logic [7:0] d);
    ld_g = g; ld_mem = mem; ld_addr = 16'(a); ld_data = d; ld_we = 1'b1;
    @(negedge clk);
    ld_we = 1'b0;
  endtask

  task automatic model_ksa();
    logic [7:0] key [3];
    logic [7:0] jj, t;
    key = '{8'h4B, 8'h65, 8'h79};
    for (int a = 0; a < 256; a++) s_ref[a] = 8'(a);
    jj = 8'h00;
    for (int a = 0; a < 256; a++) begin
      jj = jj + s_ref[a] + key[a % 3];
      t = s_ref[a]; s_ref[a] = s_ref[jj]; s_ref[jj] = t;
    end
    mi = 8'h00; mj = 8'h00;
  endtask

  task automatic model_next(output logic [7:0] ks);
    logic [7:0] t, idx;
    mi = mi + 8'd1;
    mj = mj + s_ref[mi];
    t = s_ref[mi]; s_ref[mi] = s_ref[mj]; s_ref[mj] = t;
    idx = s_ref[mi] + s_ref[mj];
    ks = s_ref[idx];
  endtask

  task automatic load_s(input int g);
    for (int a = 0; a < 256; a++) load_byte(g, 0, a, s_ref[a]);
  endtask

  task automatic push(input int g, input int a, input logic [7:0] d);
    exp_q.push_back({2'(g), 16'(a), d});
  endtask

  task automatic run(input int g, input int hold, input int maxc, output int n);
    @(negedge clk);
    en_v[g] = 1'b1;
    repeat (hold) @(negedge clk);
    en_v[g] = 1'b0;
    n = 0;
    while (rdy_v[g] !== 1'b1 && n < maxc) begin
      @(negedge clk);
      n++;
    end
    chk("rdy_return_in_budget", int'(n < maxc), 1);
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("rdy_one_cycle_after_last_write", cyc - last_wr[g], 1);
  endtask

  initial begin
    logic [7:0] ct9 [10];
    logic [7:0] pt9 [9];
    logic [7:0] ks, cb;
    int n, w0, mism;

    ct9 = '{8'h09, 8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
    pt9 = '{8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
    rst_n = 1'b0; en_v = 3'b000; ld_we = 1'b0; ld_g = 0; ld_mem = 0;
    ld_addr = '0; ld_data = '0; sb_en = 1'b1;

    repeat (3) @(negedge clk);
    chk("reset_rdy", int'(rdy_v), 7);
    chk("reset_s_wren", int'(s_wren_v), 0);
    chk("reset_pt_wren", int'(pt_wren_v), 0);
    chk("reset_pt_addr", int'(pt_addr_v[0]), 0);
    chk("reset_ct_addr", int'(ct_addr_v[2]), 0);
    chk("reset_s_addr", int'(s_addr_v[1]), 0);
    chk("reset_pt_data", int'(pt_data_v[0]), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Key "Key", all-zero body exposes the raw keystream.
    model_ksa(); load_s(0);
    load_byte(0, 1, 0, 8'h04);
    for (int a = 1; a < 5; a++) load_byte(0, 1, a, 8'h00);
    push(0, 0, 8'h04); push(0, 1, 8'hEB); push(0, 2, 8'h9F); push(0, 3, 8'h77); push(0, 4, 8'h81);
    run(0, 1, 200, n);
    chk("t1_rdy_after", int'(rdy_v[0]), 1);

    model_ksa(); load_s(1);
    load_byte(1, 1, 0, 8'h04);
    for (int a = 1; a < 5; a++) load_byte(1, 1, a, 8'h00);
    push(1, 0, 8'h04); push(1, 1, 8'h81); push(1, 2, 8'hB7); push(1, 3, 8'h34); push(1, 4, 8'hCA);
    run(1, 1, 300, n);

    model_ksa(); load_s(0);
    for (int a = 0; a < 10; a++) load_byte(0, 1, a, ct9[a]);
    push(0, 0, 8'h09);
    for (int a = 0; a < 9; a++) push(0, a + 1, pt9[a]);
    run(0, 1, 300, n);
    for (int a = 0; a < 9; a++) model_next(ks);
    mism = 0;
    for (int a = 0; a < 256; a++) if (g_inst[0].s_mem[a] !== s_ref[a]) mism++;
    chk("t3_final_s_mismatches", mism, 0);

    model_ksa(); load_s(0);
    load_byte(0, 1, 0, 8'h00);
    push(0, 0, 8'h00);
    w0 = wr_cnt[0];
    run(0, 1, 200, n);
    chk("len0_rdy_within_4", int'(n <= 4), 1);
    chk("len0_pt_writes", wr_cnt[0] - w0, 1);
    mism = 0;
    for (int a = 0; a < 256; a++) if (g_inst[0].s_mem[a] !== s_ref[a]) mism++;
    chk("len0_s_unchanged_mismatches", mism, 0);

    // 300-byte message on the wide instance; i wraps past 255.
    model_ksa(); load_s(2);
    load_byte(2, 1, 0, 8'h2C); load_byte(2, 1, 1, 8'h01);
    push(2, 0, 8'h2C); push(2, 1, 8'h01);
    for (int k = 0; k < 300; k++) begin
      cb = 8'(k * 37 + 11);
      load_byte(2, 1, k + 2, cb);
      model_next(ks);
      push(2, k + 2, cb ^ ks);
    end
    w0 = wr_cnt[2];
    run(2, 1, 5000, n);
    chk("wide_pt_writes", wr_cnt[2] - w0, 302);
    mism = 0;
    for (int a = 0; a < 256; a++) if (g_inst[2].s_mem[a] !== s_ref[a]) mism++;
    chk("wide_final_s_mismatches", mism, 0);

    // Abort a run with reset, then a clean rerun with en held high.
    model_ksa(); load_s(0);
    for (int a = 0; a < 10; a++) load_byte(0, 1, a, ct9[a]);
    sb_en = 1'b0;
    en_v[0] = 1'b1;
    @(negedge clk);
    en_v[0] = 1'b0;
    repeat (25) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_rdy", int'(rdy_v[0]), 1);
    chk("midrst_pt_wren", int'(pt_wren_v[0]), 0);
    chk("midrst_s_wren", int'(s_wren_v[0]), 0);
    @(negedge clk);
    chk("midrst_s_wren_held", int'(s_wren_v), 0);
    rst_n = 1'b1;
    @(negedge clk);
    sb_en = 1'b1;

    model_ksa(); load_s(0);
    push(0, 0, 8'h09);
    for (int a = 0; a < 9; a++) push(0, a + 1, pt9[a]);
    w0 = wr_cnt[0];
    run(0, 30, 500, n);
    repeat (20) @(negedge clk);
    chk("en_held_single_run_writes", wr_cnt[0] - w0, 10);
    chk("en_held_rdy_idle", int'(rdy_v[0]), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/prga_stream.md
Name: prga_stream

Overview:
- Parametrised successor to the lab-3 RC4 PRGA datapath.
- Starts from an S-box that the KSA has already loaded into on-chip S memory.
- Reads a length-prefixed ciphertext from CT memory, generates the RC4 keystream, and writes the length-prefixed plaintext (ct XOR pad) to PT memory.
- Adds three things the original does not have: RC4-drop[N] keystream discard, a wider message address space, and a multi-byte length prefix.

Parameters:
- DROP_N, 0: keystream bytes generated and discarded before the first message byte (0 = plain RC4).
- ADDR_W, 8: width of ct_addr/pt_addr; 8..16.
- LEN_BYTES, 1: length-prefix bytes at address 0.., little-endian; 1 or 2. Must satisfy 8*LEN_BYTES <= ADDR_W+8.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  start request; honoured only while rdy=1
- rdy  out  1  idle/ready
- s_addr  out  8  S memory address
- s_rddata  in  8  S read data; synchronous RAM, valid 1 cycle after address
- s_wrdata  out  8  S write data
- s_wren  out  1  S write enable
- ct_addr  out  ADDR_W  CT memory address (read-only)
- ct_rddata  in  8  CT read data, 1-cycle latency
- pt_addr  out  ADDR_W  PT memory address
- pt_rddata  in  8  unused; kept for memory-wrapper compatibility
- pt_wrdata  out  8  PT write data
- pt_wren  out  1  PT write enable

Behaviour:
- Reset (async, rst_n=0): FSM goes to IDLE.
  - rdy=1; s_wren=0, pt_wren=0.
  - All addresses and write data 0; i=j=0, counters 0.
- Handshake:
  - en sampled at a rising edge while rdy=1 starts a run; rdy goes to 0 the next cycle.
  - rdy returns to 1 exactly one cycle after the last PT write.
  - en while rdy=0 is ignored.
- FSM states: IDLE -> RD_LEN -> WR_LEN -> (DROP loop, DROP_N iterations) -> (MSG loop, len iterations) -> IDLE.
- RD_LEN:
  - Read ct[0..LEN_BYTES-1] and assemble len little-endian.
  - Clamp len to 2^ADDR_W - LEN_BYTES.
- WR_LEN: copy the original header bytes unchanged to pt[0..LEN_BYTES-1].
- Per iteration, i, j are 8-bit with mod-256 wrap (255+1 -> 0):
  - i = i+1
  - read si = s[i]
  - j = j+si
  - read sj = s[j]
  - write s[i]=sj, then s[j]=si (two separate write cycles)
  - read pad = s[si+sj]
- Swap must use the registered si/sj values, never re-read data. When i==j, both writes carry the same value; this is legal.
- DROP loop: performs the full S update but issues no CT read and no PT write.
- MSG loop, message index k = 1..len:
  - ct[LEN_BYTES+k-1] may be read in parallel with the S accesses.
  - Write pt[LEN_BYTES+k-1] = pad ^ ct.
- Timing:
  - At most 8 cycles per MSG iteration and 7 per DROP iteration.
  - At most one write enable high per cycle per memory.
  - pt_wren is asserted for exactly one cycle per byte.
- len=0: only the header is written; DROP iterations still execute, so S is advanced.
- Reset mid-run: immediate return to IDLE with wren low. Memory contents already written stay; no cleanup.
- i and j start at 0 on every run. S is not re-initialised by this block; the KSA must reload S between messages.

Decomposition:
- Package prga_pkg holds:
  - state enum prga_state_t
  - S_W=8 and S_DEPTH=256
  - helper function len_max(ADDR_W, LEN_BYTES)
- No sub-module. A single FSM plus i/j/k/drop counters and si/sj/pad registers is natural, about 200 lines.
- The bench reuses the existing RC4 reference model task and simple 1-cycle RAM models.

Test Plan:
- Key 24'h4B6579, S preloaded with the post-KSA state, DROP_N=0, ct={04,00,00,00,00} -> pt={04,EB,9F,77,81}; rdy high afterwards.
- Same S, DROP_N=3, same ct -> pt={04,81,B7,34,CA}.
- DROP_N=0, ct = {09} followed by BB F3 16 E8 D9 40 AF 0A D3 -> pt = "Plaintext" (50 6C 61 69 6E 74 65 78 74) with header 09; final S matches the model.
- len=0, DROP_N=0 -> exactly one pt write (pt[0]=00); rdy returns within 4 cycles; S unchanged.
- ADDR_W=10, LEN_BYTES=2, header {2C,01}=300 bytes -> 302 PT writes; output matches the model; i wraps past 255 correctly.
- Pulse rst_n low mid-message, then restart with en -> rdy=1 and no wren during reset; a fresh run after S reload gives the correct result. en held high during a run -> exactly one run.
